// File: rtl/pps_freq_meter.sv
// Reference-clock frequency meter gated by GPS 1PPS, with a phase-locked 1PPS
// generator (holdover) and an addressed SPI register port.
module pps_freq_meter #(
    parameter int CNT_W     = 28,
    parameter int GATE_LOG2 = 3,
    parameter int PULSE_W   = 16,
    parameter int PER_RST   = 10000000
) (
    input  logic clk,
    input  logic nreset,
    input  logic pps_in,
    input  logic spi_clk,
    input  logic spi_sen,
    input  logic spi_in,
    output logic spi_out,
    output logic spi_out_oen,
    output logic pps_out,
    output logic pps_valid,
    output logic meas_new
);

    localparam int EDG_W = GATE_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] PER_INIT = CNT_W'(PER_RST);
    localparam logic [CNT_W-1:0] PULSE_C  = CNT_W'(PULSE_W);
    localparam logic [2:0]       GATE_MAX = 3'(GATE_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} spi_state_t;

    logic [2:0] pps_sync, sck_sync, sen_sync;
    logic [1:0] din_sync;
    logic       pps_edge, spi_rise, sen_rise, sen_act, din;

    spi_state_t  spi_state;
    logic [5:0]  bcnt;
    logic [7:0]  cmd;
    logic [31:0] shreg, rd_mux;
    logic [1:0]  rd_addr;
    logic        wr_commit, rd_clear, wr_ctrl, wr_per;

    logic [2:0]       gate_sel;
    logic             lock_en, out_en;
    logic [CNT_W-1:0] period_reg;

    logic [CNT_W-1:0] cnt, cnt_inc, meas_cnt;
    logic             ovf, ovf_nxt, meas_ovf, lost, armed, capture;
    logic [EDG_W-1:0] edges, edges_inc, gate_tgt;
    logic [3:0]       edges_st;

    logic [CNT_W-1:0] ph, ph_eff, period_act;
    logic [CNT_W:0]   wd, wd_inc, wd_lim;
    logic             realign, wrap;

    // Two-flop synchronisers; the third pps/sck/sen bit is the edge-detect history.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            pps_sync <= '0;
            sck_sync <= '0;
            sen_sync <= '1;
            din_sync <= '0;
        end else begin
            pps_sync <= {pps_sync[1:0], pps_in};
            sck_sync <= {sck_sync[1:0], spi_clk};
            sen_sync <= {sen_sync[1:0], spi_sen};
            din_sync <= {din_sync[0], spi_in};
        end
    end

    assign pps_edge = pps_sync[1] & ~pps_sync[2];
    assign spi_rise = sck_sync[1] & ~sck_sync[2];
    assign sen_rise = sen_sync[1] & ~sen_sync[2];
    assign sen_act  = ~sen_sync[1];
    assign din      = din_sync[1];

    // Frame handshake: bits are taken on spi_rise while select is low; the frame
    // is judged once, on the select release, by its command and bit count.
    assign rd_addr   = {cmd[0], din};
    assign wr_commit = sen_rise & cmd[7] & (bcnt == 6'd40);
    assign rd_clear  = sen_rise & ~cmd[7] & (cmd[1:0] == 2'd0) & (bcnt >= 6'd8);
    assign wr_ctrl   = wr_commit & (cmd[1:0] == 2'd1);
    assign wr_per    = wr_commit & (cmd[1:0] == 2'd2);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            spi_state <= S_IDLE;
            bcnt      <= '0;
            cmd       <= '0;
            shreg     <= '0;
        end else if (!sen_act) begin
            spi_state <= S_IDLE;
            bcnt      <= '0;
        end else begin
            case (spi_state)
                S_IDLE: begin
                    spi_state <= S_CMD;
                    bcnt      <= '0;
                    cmd       <= '0;
                end
                S_CMD: if (spi_rise) begin
                    cmd  <= {cmd[6:0], din};
                    bcnt <= bcnt + 6'd1;
                    if (bcnt == 6'd7) begin
                        spi_state <= S_DATA;
                        shreg     <= rd_mux;
                    end
                end
                S_DATA: if (spi_rise) begin
                    // Shared shifter: read data leaves at [31], write data enters at [0].
                    shreg <= {shreg[30:0], din};
                    if (bcnt != 6'd63) bcnt <= bcnt + 6'd1;
                end
                default: spi_state <= S_IDLE;
            endcase
        end
    end

    assign spi_out     = (spi_state == S_DATA) & ~cmd[7] & (bcnt < 6'd40) & shreg[31];
    assign spi_out_oen = ~spi_sen;

    assign edges_st = 4'(edges);

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            2'd0: begin
                rd_mux[31]        = meas_new;
                rd_mux[30]        = meas_ovf;
                rd_mux[CNT_W-1:0] = meas_cnt;
            end
            2'd1: begin
                rd_mux[2:0] = gate_sel;
                rd_mux[4]   = lock_en;
                rd_mux[5]   = out_en;
            end
            2'd2: rd_mux[CNT_W-1:0] = period_reg;
            default: begin
                rd_mux[0]   = pps_valid;
                rd_mux[1]   = lost;
                rd_mux[7:4] = edges_st;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            gate_sel   <= '0;
            lock_en    <= 1'b0;
            out_en     <= 1'b0;
            period_reg <= PER_INIT;
        end else begin
            if (wr_ctrl) begin
                gate_sel <= (shreg[2:0] > GATE_MAX) ? GATE_MAX : shreg[2:0];
                lock_en  <= shreg[4];
                out_en   <= shreg[5];
            end
            if (wr_per)
                period_reg <= (shreg[CNT_W-1:0] < PER_MIN) ? PER_MIN : shreg[CNT_W-1:0];
        end
    end

    // Measurement: the captured count includes the capture cycle itself.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign ovf_nxt   = ovf | (cnt_inc == CNT_MAX);
    assign edges_inc = edges + EDG_W'(1);
    assign gate_tgt  = EDG_W'(1) << gate_sel;
    assign capture   = armed & pps_edge & (edges_inc == gate_tgt) & ~wr_ctrl;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            edges    <= '0;
            armed    <= 1'b0;
            meas_new <= 1'b0;
            meas_ovf <= 1'b0;
            meas_cnt <= '0;
            lost     <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            ovf <= ovf_nxt;
            if (wr_ctrl) begin
                armed <= 1'b0;
                edges <= '0;
            end else if (pps_edge) begin
                if (!armed) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    edges <= '0;
                end else if (capture) begin
                    meas_new <= 1'b1;
                    meas_ovf <= ovf_nxt;
                    meas_cnt <= cnt_inc;
                    cnt      <= '0;
                    ovf      <= 1'b0;
                    edges    <= '0;
                    if (meas_new) lost <= 1'b1;
                end else begin
                    edges <= edges_inc;
                end
            end
            if (rd_clear && !capture) begin
                meas_new <= 1'b0;
                lost     <= 1'b0;
            end
        end
    end

    // A locked edge counts as phase 0 and also acts as a wrap for period updates.
    assign realign = lock_en & pps_edge;
    assign wrap    = (ph >= period_act - CNT_W'(1));
    assign ph_eff  = realign ? '0 : ph;
    assign wd_inc  = wd + (CNT_W+1)'(1);
    assign wd_lim  = {period_reg, 1'b0};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ph         <= '0;
            period_act <= PER_INIT;
            pps_out    <= 1'b0;
            pps_valid  <= 1'b0;
            wd         <= '0;
        end else begin
            pps_out <= out_en & (ph_eff < PULSE_C);
            if (realign) begin
                ph         <= CNT_W'(1);
                period_act <= period_reg;
            end else if (wrap) begin
                ph         <= '0;
                period_act <= period_reg;
            end else begin
                ph <= ph + CNT_W'(1);
            end
            if (pps_edge) begin
                pps_valid <= 1'b1;
                wd        <= '0;
            end else begin
                if (wd_inc >= wd_lim) pps_valid <= 1'b0;
                if (wd < wd_lim) wd <= wd_inc;
            end
        end
    end

endmodule
